firebird7_in_gate1_tessent_data_mux_ctrl_w19: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl_w19

---
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg.sv | 36 +++
 rtl/firebird7_in_gate1_tessent_tdr_w21.sv | 81 ++++++++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv | 173 +++++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg
//
// Shared definitions for the IJTAG data-mux override controller:
//   - state_t      : 2-bit controller state encoding (also exported for debug)
//   - TIMER_W      : width of the quiesce-acknowledge timer
//   - field helpers: bit positions of the takeover/force control bits that sit
//                    above the data field in the TDR shift register
// -----------------------------------------------------------------------------
package firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg;

  localparam int DEFAULT_WIDTH = 19;
  localparam int TIMER_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_REL    = 2'd3
  } state_t;

  // TDR layout for a data field of 'width' bits:
  //   [width+1] takeover, [width] force, [width-1:0] data
  function automatic int force_idx(input int width);
    return width;
  endfunction

  function automatic int takeover_idx(input int width);
    return width + 1;
  endfunction

  function automatic int tdr_len(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w21.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_w21
//
// IJTAG test data register: shift, capture and update stages only.
// Operation priority when several enables coincide: capture > shift > update.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   sel, ce, se, ue, si network select, capture/shift/update enables, scan in
//   capture_data        value parallel-loaded on capture
//   so                  scan out (bit 0 of the shift register)
//   upd_takeover/force  update-stage control bits
//   upd_data            update-stage data field
//   upd_strobe          high for the one cycle right after an update edge,
//                       aligned with the freshly loaded update values
//   takeover_update     high in the cycle an update with takeover=1 is taken
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_w21
  import firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             ce,
  input  logic             se,
  input  logic             ue,
  input  logic             si,
  input  logic [WIDTH+1:0] capture_data,
  output logic             so,
  output logic             upd_takeover,
  output logic             upd_force,
  output logic [WIDTH-1:0] upd_data,
  output logic             upd_strobe,
  output logic             takeover_update
);

  localparam int LEN = tdr_len(WIDTH);
  localparam int TK  = takeover_idx(WIDTH);
  localparam int FI  = force_idx(WIDTH);

  logic [LEN-1:0] shift_q;
  logic           capture_en;
  logic           shift_en;
  logic           update_en;

  assign capture_en = sel & ce;
  assign shift_en   = sel & se & ~ce;
  assign update_en  = sel & ue & ~ce & ~se;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (capture_en) begin
      shift_q <= capture_data;
    end else if (shift_en) begin
      shift_q <= {si, shift_q[LEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_takeover <= 1'b0;
      upd_force    <= 1'b0;
      upd_data     <= '0;
      upd_strobe   <= 1'b0;
    end else begin
      upd_strobe <= update_en;
      if (update_en) begin
        upd_takeover <= shift_q[TK];
        upd_force    <= shift_q[FI];
        upd_data     <= shift_q[WIDTH-1:0];
      end
    end
  end

  assign so              = shift_q[0];
  assign takeover_update = update_en & shift_q[TK];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl_w19
//
// IJTAG-controlled override of a functional data bus. Software shifts
// {takeover, force, data} into the TDR and updates; the controller then asks
// the functional side to quiesce and, once acknowledged (or immediately when
// force=1), asserts ijtag_select so the parent's data mux drives ijtag_data_out.
//
// Quiesce handshake: quiesce_req is a level request held for the whole
// override; quiesce_ack is a level response sampled only while waiting in
// ST_REQ. ack is ignored in every other state, so an ack that drops during the
// override does not end it -- only a software update with takeover=0 does.
// ijtag_select is always asserted strictly inside the quiesce_req window
// (except for force mode, where quiesce_req is never raised).
//
// Ports:
//   ijtag_tck, ijtag_reset            clock, async active-low reset
//   ijtag_sel/ce/se/ue/si, ijtag_so   IJTAG TDR access
//   functional_data_in                bus value observed on capture
//   quiesce_ack / quiesce_req         quiesce handshake with functional side
//   ijtag_data_out, ijtag_select      override value and mux select
//   fsm_state                         controller state, for debug/checkers
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_ctrl_w19
  import firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic             quiesce_ack,
  output logic             quiesce_req,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select,
  output logic [1:0]       fsm_state
);

  localparam logic [TIMER_W:0] ACK_LIMIT = (TIMER_W + 1)'(ACK_TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W:0]     timer_inc;
  logic [TIMER_W-1:0]   timer_sat;
  logic                 select_q, select_d;
  logic                 qreq_q, qreq_d;
  logic                 flag_q, flag_d;
  logic                 timeout_hit;

  logic                 upd_takeover;
  logic                 upd_force;
  logic                 upd_strobe;
  logic                 takeover_update;

  firebird7_in_gate1_tessent_tdr_w21 #(
    .WIDTH(WIDTH)
  ) u_tdr (
    .clk             (ijtag_tck),
    .rst_n           (ijtag_reset),
    .sel             (ijtag_sel),
    .ce              (ijtag_ce),
    .se              (ijtag_se),
    .ue              (ijtag_ue),
    .si              (ijtag_si),
    .capture_data    ({select_q, flag_q, functional_data_in}),
    .so              (ijtag_so),
    .upd_takeover    (upd_takeover),
    .upd_force       (upd_force),
    .upd_data        (ijtag_data_out),
    .upd_strobe      (upd_strobe),
    .takeover_update (takeover_update)
  );

  // Timer counts REQ cycles; one extra bit detects saturation so it never wraps.
  assign timer_inc = {1'b0, timer_q} + {{TIMER_W{1'b0}}, 1'b1};
  assign timer_sat = timer_inc[TIMER_W] ? {TIMER_W{1'b1}} : timer_inc[TIMER_W-1:0];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    select_d    = select_q;
    qreq_d      = qreq_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // React to a new update only: a stale takeover=1 left behind by a
        // timeout must not restart the request on its own.
        if (upd_strobe && upd_takeover) begin
          if (upd_force) begin
            state_d  = ST_ACTIVE;
            select_d = 1'b1;
            qreq_d   = 1'b0;
          end else begin
            state_d = ST_REQ;
            qreq_d  = 1'b1;
            timer_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (!upd_takeover) begin
          state_d = ST_IDLE;
          qreq_d  = 1'b0;
        end else if (quiesce_ack) begin
          // Ack is checked ahead of the timeout, so a tie goes to ACTIVE.
          state_d  = ST_ACTIVE;
          select_d = 1'b1;
        end else if (timer_inc >= ACK_LIMIT) begin
          state_d     = ST_IDLE;
          qreq_d      = 1'b0;
          timeout_hit = 1'b1;
        end else begin
          timer_d = timer_sat;
        end
      end
      ST_ACTIVE: begin
        if (!upd_takeover) begin
          state_d  = ST_REL;
          select_d = 1'b0;
        end
      end
      ST_REL: begin
        // select already low for a cycle; now let the functional side go.
        state_d  = ST_IDLE;
        select_d = 1'b0;
        qreq_d   = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        select_d = 1'b0;
        qreq_d   = 1'b0;
      end
    endcase
  end

  // A new takeover request clears the sticky flag from a previous timeout.
  always_comb begin
    flag_d = flag_q;
    if (takeover_update) begin
      flag_d = 1'b0;
    end else if (timeout_hit) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      select_q <= 1'b0;
      qreq_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      select_q <= select_d;
      qreq_q   <= qreq_d;
      flag_q   <= flag_d;
    end
  end

  assign ijtag_select = select_q;
  assign quiesce_req  = qreq_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;
  import firebird7_in_gate1_tessent_data_mux_ctrl_w19_pkg::*;

  localparam int W           = 19;
  localparam int ACK_TIMEOUT = 255;
  localparam int OW          = W + 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0, ack = 1'b0;
  logic [W-1:0] fdata = '0;
  logic         so, qreq, select;
  logic [W-1:0] data_out;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
    .WIDTH(W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdata),
    .quiesce_ack        (ack),
    .quiesce_req        (qreq),
    .ijtag_data_out     (data_out),
    .ijtag_select       (select),
    .fsm_state          (fsm_state)
  );

  // ---------------- reference model ----------------
  // Behavioural view: "mode" is where the override stands (0 quiet, 1 asking,
  // 2 overriding, 3 letting go); the wait is measured as elapsed edges since
  // the request started, using an absolute edge counter.
  logic [W+1:0] m_tdr;
  logic [W-1:0] m_data;
  logic         m_tk, m_force, m_fresh, m_flag, m_select, m_req;
  int           m_mode, m_cyc, m_ask_start;
  logic         c_cap, c_shf, c_upd, c_timeout, c_clear, n_sel, n_req;
  int           n_mode;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_tdr = '0; m_data = '0; m_tk = 0; m_force = 0; m_fresh = 0;
      m_flag = 0; m_select = 0; m_req = 0; m_mode = 0; m_cyc = 0; m_ask_start = 0;
    end else begin
      c_cap = sel && ce;
      c_shf = sel && se && !ce;
      c_upd = sel && ue && !ce && !se;
      n_mode = m_mode; n_sel = m_select; n_req = m_req; c_timeout = 0;
      case (m_mode)
        0: if (m_fresh && m_tk) begin
             if (m_force) begin n_mode = 2; n_sel = 1; n_req = 0; end
             else begin n_mode = 1; n_req = 1; m_ask_start = m_cyc; end
           end
        1: if (!m_tk) begin n_mode = 0; n_req = 0; end
           else if (ack) begin n_mode = 2; n_sel = 1; end
           else if (m_cyc - m_ask_start >= ACK_TIMEOUT) begin
             n_mode = 0; n_req = 0; c_timeout = 1;
           end
        2: if (!m_tk) begin n_mode = 3; n_sel = 0; end
        default: begin n_mode = 0; n_req = 0; n_sel = 0; end
      endcase
      c_clear = c_upd && m_tdr[W+1];
      if (c_upd) begin
        m_tk = m_tdr[W+1]; m_force = m_tdr[W]; m_data = m_tdr[W-1:0];
      end
      m_fresh = c_upd;
      if (c_cap) m_tdr = {m_select, m_flag, fdata};
      else if (c_shf) m_tdr = (m_tdr >> 1) | ((W+2)'(si) << (W+1));
      if (c_clear) m_flag = 0;
      else if (c_timeout) m_flag = 1;
      m_mode = n_mode; m_select = n_sel; m_req = n_req;
      m_cyc++;
    end
    exp_q.push_back({m_select, m_req, m_tdr[0], m_data});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [OW-1:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({select, qreq, so, data_out} !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got sel/req/so/data=%h expected %h",
                 $time, {select, qreq, so, data_out}, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [W+1:0] v);
    for (int i = 0; i < W + 2; i++) begin
      sel = 1; se = 1; ce = 0; ue = 0; si = v[i];
      tick();
    end
    se = 0; si = 0;
  endtask

  task automatic do_update();
    sel = 1; ue = 1; ce = 0; se = 0;
    tick();
    ue = 0;
  endtask

  task automatic do_capture();
    sel = 1; ce = 1;
    tick();
    ce = 0;
  endtask

  task automatic read_out();
    for (int i = 0; i < W + 2; i++) begin
      sel = 1; se = 1; si = 1'($urandom_range(0, 1));
      tick();
    end
    se = 0; si = 0;
  endtask

  // Deselected cycles with random enables: nothing may happen in the TDR.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sel = 0;
      ce = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
      ue = 1'($urandom_range(0, 1)); si = 1'($urandom_range(0, 1));
      fdata = W'($urandom);
      tick();
    end
    ce = 0; se = 0; ue = 0; si = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int qcount;
    logic [W-1:0] d;
    logic f;

    repeat (3) tick();
    check("reset_outputs", {select, qreq, so, data_out}, '0);
    check("reset_state", fsm_state, ST_IDLE);
    rst_n = 1;
    tick();

    // Acknowledged takeover of 5A5A5, ack 3 cycles late, ack drop ignored.
    shift_in({1'b1, 1'b0, 19'h5A5A5});
    do_update();
    idle(3);
    ack = 1;
    idle(4);
    check("active_state", fsm_state, ST_ACTIVE);
    check("active_data", data_out, 19'h5A5A5);
    ack = 0;
    idle(3);
    do_capture();
    read_out();
    shift_in({1'b0, 1'b0, 19'h12345});
    do_update();
    idle(4);
    check("release_state", fsm_state, ST_IDLE);
    check("release_req", qreq, 0);

    // Timeout: ack never arrives.
    shift_in({1'b1, 1'b0, W'($urandom)});
    do_update();
    qcount = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (qreq) qcount++;
    end
    check("timeout_req_cycles", qcount, ACK_TIMEOUT);
    check("timeout_state", fsm_state, ST_IDLE);
    do_capture();
    read_out();

    // Force with ack held low.
    shift_in({1'b1, 1'b1, W'($urandom)});
    do_update();
    idle(5);
    check("force_req_low", qreq, 0);
    shift_in({1'b0, 1'b0, W'($urandom)});
    do_update();
    idle(3);

    // ce/se/ue together: capture only.
    fdata = 19'h7FFFF;
    sel = 1; ce = 1; se = 1; ue = 1;
    tick();
    ce = 0; se = 0; ue = 0;
    read_out();

    // Randomized takeovers.
    for (int n = 0; n < 8; n++) begin
      d = W'($urandom);
      f = ($urandom_range(0, 3) == 0);
      shift_in({1'b1, f, d});
      do_update();
      idle($urandom_range(0, 12));
      ack = 1;
      idle($urandom_range(1, 4));
      ack = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) begin
        fdata = W'($urandom);
        do_capture();
        read_out();
      end
      shift_in({1'b0, 1'b0, W'($urandom)});
      do_update();
      idle(3);
      ack = 0;
    end

    // Asynchronous reset in the middle of a forced override.
    shift_in({1'b1, 1'b1, W'($urandom)});
    do_update();
    idle(3);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    check("async_rst_select", select, 0);
    check("async_rst_outputs", {select, qreq, so, data_out}, '0);
    check("async_rst_state", fsm_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(3);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
